// File: rtl/coincidence_ctrl.sv
// coincidence_ctrl: turns two synchronized detector levels into counter
// increment pulses. An A/B rising-edge pair inside a window produces a
// coincidence pulse followed by a dead time. Edges that arrive during the
// dead time are counted in a saturating drop counter.
module coincidence_ctrl #(
    parameter int WINDOW_CYCLES = 32,
    parameter int DEAD_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hit_a,
    input  logic       hit_b,
    input  logic       clear,
    output logic       inc_a,
    output logic       inc_b,
    output logic       inc_c,
    output logic       busy,
    output logic [7:0] drop_cnt,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        WAIT_A = 2'd2,
        DEAD   = 2'd3
    } state_t;

    localparam logic [7:0] WIN_LOAD  = 8'(WINDOW_CYCLES);
    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] win_q, win_d;
    logic [7:0] dead_q, dead_d;
    logic [7:0] drop_d;
    logic       hit_a_q, hit_b_q;
    logic       inc_a_d, inc_b_d, inc_c_d;
    logic [8:0] drop_sum;
    logic       rise_a, rise_b;

    // Only a low-to-high transition is an event; a held level never counts.
    assign rise_a = hit_a & ~hit_a_q;
    assign rise_b = hit_b & ~hit_b_q;

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    // State, counters, history and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            win_q    <= 8'd0;
            dead_q   <= 8'd0;
            drop_cnt <= 8'd0;
            hit_a_q  <= 1'b0;
            hit_b_q  <= 1'b0;
            inc_a    <= 1'b0;
            inc_b    <= 1'b0;
            inc_c    <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            dead_q   <= dead_d;
            drop_cnt <= drop_d;
            // History keeps tracking during clear so a level held across
            // the clear cycle does not look like a fresh edge afterwards.
            hit_a_q  <= hit_a;
            hit_b_q  <= hit_b;
            inc_a    <= inc_a_d;
            inc_b    <= inc_b_d;
            inc_c    <= inc_c_d;
        end
    end

    // Next-state, counter updates and pulse requests for the next cycle.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        dead_d   = dead_q;
        drop_d   = drop_cnt;
        inc_a_d  = 1'b0;
        inc_b_d  = 1'b0;
        inc_c_d  = 1'b0;
        drop_sum = {1'b0, drop_cnt} + 9'(rise_a) + 9'(rise_b);

        if (clear) begin
            state_d = IDLE;
            win_d   = 8'd0;
            dead_d  = 8'd0;
            drop_d  = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise_a && rise_b) begin
                        inc_a_d = 1'b1;
                        inc_b_d = 1'b1;
                        inc_c_d = 1'b1;
                        state_d = DEAD;
                        dead_d  = DEAD_LOAD;
                    end else if (rise_a) begin
                        inc_a_d = 1'b1;
                        state_d = WAIT_B;
                        win_d   = WIN_LOAD;
                    end else if (rise_b) begin
                        inc_b_d = 1'b1;
                        state_d = WAIT_A;
                        win_d   = WIN_LOAD;
                    end
                end
                WAIT_B: begin
                    // Edges are checked before expiry, so an edge on the
                    // last window cycle still counts as a coincidence.
                    if (rise_b) begin
                        inc_a_d = rise_a;
                        inc_b_d = 1'b1;
                        inc_c_d = 1'b1;
                        state_d = DEAD;
                        win_d   = 8'd0;
                        dead_d  = DEAD_LOAD;
                    end else if (rise_a) begin
                        inc_a_d = 1'b1;
                        win_d   = WIN_LOAD;
                    end else if (win_q <= 8'd1) begin
                        state_d = IDLE;
                        win_d   = 8'd0;
                    end else begin
                        win_d = win_q - 8'd1;
                    end
                end
                WAIT_A: begin
                    if (rise_a) begin
                        inc_a_d = 1'b1;
                        inc_b_d = rise_b;
                        inc_c_d = 1'b1;
                        state_d = DEAD;
                        win_d   = 8'd0;
                        dead_d  = DEAD_LOAD;
                    end else if (rise_b) begin
                        inc_b_d = 1'b1;
                        win_d   = WIN_LOAD;
                    end else if (win_q <= 8'd1) begin
                        state_d = IDLE;
                        win_d   = 8'd0;
                    end else begin
                        win_d = win_q - 8'd1;
                    end
                end
                DEAD: begin
                    // Dropped edges are tallied, saturating rather than wrapping.
                    drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
                    if (dead_q <= 8'd1) begin
                        state_d = IDLE;
                        dead_d  = 8'd0;
                    end else begin
                        dead_d = dead_q - 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coincidence_ctrl.sv
// Testbench for coincidence_ctrl with default parameters (window 32, dead 16).
module tb_coincidence_ctrl;

    logic       clk;
    logic       rst_n;
    logic       hit_a;
    logic       hit_b;
    logic       clear;
    logic       inc_a;
    logic       inc_b;
    logic       inc_c;
    logic       busy;
    logic [7:0] drop_cnt;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Accumulators over a sequence of cycles
    int cnt_a, cnt_b, cnt_c, cnt_busy, last_c_k, c_alone;

    coincidence_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hit_a     (hit_a),
        .hit_b     (hit_b),
        .clear     (clear),
        .inc_a     (inc_a),
        .inc_b     (inc_b),
        .inc_c     (inc_c),
        .busy      (busy),
        .drop_cnt  (drop_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic       a;
        logic       b;
        logic       clr;
        logic       ea;
        logic       eb;
        logic       ec;
        logic       ebusy;
        logic [7:0] edrop;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic a, input logic b, input logic clr,
                                input logic ea, input logic eb, input logic ec,
                                input logic ebusy, input logic [7:0] edrop);
        vec_t v;
        v.a = a; v.b = b; v.clr = clr;
        v.ea = ea; v.eb = eb; v.ec = ec; v.ebusy = ebusy; v.edrop = edrop;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 ns after the
    // rising edge that consumed them.
    task automatic drive(input logic a, input logic b, input logic clr);
        @(negedge clk);
        hit_a = a;
        hit_b = b;
        clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_acc();
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_busy = 0; last_c_k = -1;
    endtask

    task automatic step_acc(input logic a, input logic b, input int k);
        drive(a, b, 1'b0);
        cnt_a    += int'(inc_a);
        cnt_b    += int'(inc_b);
        cnt_c    += int'(inc_c);
        cnt_busy += int'(busy);
        if (inc_c) last_c_k = k;
        if (inc_c && !inc_a && !inc_b) c_alone++;
    endtask

    // One-cycle pulses: A high at cycles a0/a1, B high at cycles b0/b1 (-1 = none)
    task automatic run_pulses(input int len, input int a0, input int a1,
                              input int b0, input int b1);
        reset_acc();
        for (int k = 0; k < len; k++)
            step_acc((k == a0) || (k == a1), (k == b0) || (k == b1), k);
    endtask

    task automatic do_clear();
        drive(1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- main test ----------------
    initial begin
        int exp_a, exp_b, exp_c;
        int prev_drop, wrap_err;
        logic pa, pb;

        rst_n = 1'b0; hit_a = 1'b0; hit_b = 1'b0; clear = 1'b0;
        c_alone = 0;
        reset_acc();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_inc_a", inc_a, 0);
        chk("reset_inc_b", inc_b, 0);
        chk("reset_inc_c", inc_c, 0);
        chk("reset_busy", busy, 0);
        chk("reset_drop", drop_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        //            a  b  clr  ia ib ic busy drop
        tbl[0]  = mk(0, 0, 0,   0, 0, 0, 0, 8'd0);
        tbl[1]  = mk(1, 1, 0,   1, 1, 1, 1, 8'd0); // simultaneous -> DEAD
        tbl[2]  = mk(1, 1, 0,   0, 0, 0, 1, 8'd0); // held levels
        tbl[3]  = mk(0, 0, 0,   0, 0, 0, 1, 8'd0);
        tbl[4]  = mk(1, 0, 0,   0, 0, 0, 1, 8'd1); // A dropped
        tbl[5]  = mk(0, 1, 0,   0, 0, 0, 1, 8'd2); // B dropped
        tbl[6]  = mk(1, 1, 0,   0, 0, 0, 1, 8'd3); // A rises, B held
        tbl[7]  = mk(0, 0, 0,   0, 0, 0, 1, 8'd3);
        tbl[8]  = mk(1, 1, 0,   0, 0, 0, 1, 8'd5); // both dropped: +2
        tbl[9]  = mk(0, 0, 1,   0, 0, 0, 0, 8'd0); // clear
        tbl[10] = mk(1, 0, 0,   1, 0, 0, 1, 8'd0); // A -> WAIT_B
        tbl[11] = mk(0, 1, 0,   0, 1, 1, 1, 8'd0); // B in window
        tbl[12] = mk(0, 0, 1,   0, 0, 0, 0, 8'd0);
        tbl[13] = mk(0, 1, 0,   0, 1, 0, 1, 8'd0); // B -> WAIT_A
        tbl[14] = mk(1, 1, 0,   1, 0, 1, 1, 8'd0); // A in window, B held
        tbl[15] = mk(0, 0, 1,   0, 0, 0, 0, 8'd0);
        tbl[16] = mk(0, 1, 0,   0, 1, 0, 1, 8'd0); // B -> WAIT_A
        tbl[17] = mk(0, 0, 0,   0, 0, 0, 1, 8'd0);
        tbl[18] = mk(0, 1, 0,   0, 1, 0, 1, 8'd0); // B again: reload
        tbl[19] = mk(1, 1, 1,   0, 0, 0, 0, 8'd0); // edges in clear ignored
        tbl[20] = mk(1, 1, 0,   0, 0, 0, 0, 8'd0); // held after clear: no edge
        tbl[21] = mk(0, 0, 0,   0, 0, 0, 0, 8'd0);

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].clr);
            chk($sformatf("vec%0d_inc_a", i), inc_a, tbl[i].ea);
            chk($sformatf("vec%0d_inc_b", i), inc_b, tbl[i].eb);
            chk($sformatf("vec%0d_inc_c", i), inc_c, tbl[i].ec);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].ebusy);
            chk($sformatf("vec%0d_drop", i), drop_cnt, tbl[i].edrop);
        end

        // B then A ten cycles later
        do_clear();
        run_pulses(40, 10, -1, 0, -1);
        chk("b_then_a_cnt_a", cnt_a, 1);
        chk("b_then_a_cnt_b", cnt_b, 1);
        chk("b_then_a_cnt_c", cnt_c, 1);
        chk("b_then_a_c_cycle", last_c_k, 10);
        chk("b_then_a_busy_cycles", cnt_busy, 26);

        // Simultaneous A and B
        do_clear();
        run_pulses(30, 0, -1, 0, -1);
        chk("simul_cnt_c", cnt_c, 1);
        chk("simul_c_cycle", last_c_k, 0);
        chk("simul_busy_cycles", cnt_busy, 16);

        // A alone, window expires
        do_clear();
        run_pulses(50, 0, -1, -1, -1);
        chk("a_alone_cnt_a", cnt_a, 1);
        chk("a_alone_cnt_c", cnt_c, 0);
        chk("a_alone_busy_cycles", cnt_busy, 32);

        // Second B edge five cycles into DEAD
        do_clear();
        run_pulses(30, 0, -1, 0, 5);
        chk("dead_edge_cnt_b", cnt_b, 1);
        chk("dead_edge_drop", drop_cnt, 1);

        // B on the last window cycle is still inside
        do_clear();
        run_pulses(60, 0, -1, 32, -1);
        chk("win_last_cnt_c", cnt_c, 1);
        chk("win_last_c_cycle", last_c_k, 32);

        // B one cycle after the window closes starts a new WAIT_A
        do_clear();
        run_pulses(80, 0, -1, 33, -1);
        chk("win_past_cnt_c", cnt_c, 0);
        chk("win_past_cnt_b", cnt_b, 1);
        chk("win_past_busy_cycles", cnt_busy, 64);

        // Second A edge reloads the window
        do_clear();
        run_pulses(60, 0, 20, 50, -1);
        chk("reload_cnt_a", cnt_a, 2);
        chk("reload_cnt_c", cnt_c, 1);
        chk("reload_c_cycle", last_c_k, 50);

        // 50 presses of 15 cycles, every 5th a simultaneous A+B
        do_clear();
        reset_acc();
        exp_a = 0; exp_b = 0; exp_c = 0;
        for (int i = 0; i < 50; i++) begin
            if (i % 5 == 4) begin
                pa = 1'b1; pb = 1'b1;
                exp_a++; exp_b++; exp_c++;
            end else if (i % 2 == 0) begin
                pa = 1'b1; pb = 1'b0;
                exp_a++;
            end else begin
                pa = 1'b0; pb = 1'b1;
                exp_b++;
            end
            for (int k = 0; k < 15; k++) step_acc(pa, pb, k);
            for (int k = 0; k < 45; k++) step_acc(1'b0, 1'b0, k);
        end
        chk("presses_cnt_a", cnt_a, exp_a);
        chk("presses_cnt_b", cnt_b, exp_b);
        chk("presses_cnt_c", cnt_c, exp_c);
        chk("presses_c_is_10", cnt_c, 10);

        // Flood of edges: drop_cnt must saturate at 255 and never wrap
        do_clear();
        reset_acc();
        prev_drop = 0;
        wrap_err = 0;
        for (int k = 0; k < 400; k++) begin
            step_acc(k % 2 == 0, k % 2 == 1, k);
            if (int'(drop_cnt) < prev_drop) wrap_err++;
            prev_drop = int'(drop_cnt);
        end
        chk("flood_drop_sat", drop_cnt, 255);
        chk("flood_no_wrap", wrap_err, 0);
        for (int k = 0; k < 40; k++) step_acc(1'b0, 1'b0, k);
        chk("flood_drop_held", drop_cnt, 255);
        chk("flood_idle_busy", busy, 0);

        // Reset mid-WAIT_B: outputs clear immediately, pending event lost
        drive(1'b1, 1'b0, 1'b0);
        chk("pre_reset_inc_a", inc_a, 1);
        chk("pre_reset_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_inc_a", inc_a, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_drop", drop_cnt, 0);
        @(negedge clk);
        hit_a = 1'b0;
        hit_b = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_level_inc_b", inc_b, 1);
        chk("post_reset_level_inc_a", inc_a, 0);
        chk("post_reset_level_inc_c", inc_c, 0);
        chk("post_reset_level_busy", busy, 1);

        chk("inc_c_without_a_or_b", c_alone, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
